// File: rtl/output_layer_mac.sv
// ---------------------------------------------------------------------------
// output_layer_mac
//
// Output (decoder) neuron of the denoising autoencoder. It sits directly
// downstream of hidden_layer and turns four hidden activations into one
// denoised 8-bit sample:
//
//   out_sample = sat( relu?( round( bias + sum_i h_i * w_i ) ) )
//
// A single signed multiplier is time-shared over four MAC cycles.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Once valid is raised, the producer holds it and the data stable until
//   the transfer. Ready may be asserted at any time and has no effect while
//   valid is low.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   in_valid    h0..h3, w0..w3 and bias are valid
//   in_ready    block can accept a new input set (high only in IDLE)
//   h0..h3      hidden activations, signed Q(DATA_W-FRAC_BITS-1).FRAC_BITS
//   w0..w3      output-layer weights, same format
//   bias        output-layer bias, same format as the output
//   out_valid   out_sample is valid
//   out_ready   consumer accepts out_sample
//   out_sample  denoised sample, signed, DATA_W bits
//   dbg_state   current FSM state (0=IDLE 1=MAC 2=DONE 3=HOLD)
//
// Timing
//   Capture at edge T, MAC at T+1..T+4, result registered at T+5 with
//   out_valid=1. The sample is held until out_ready is seen, after which
//   the block returns to IDLE and can capture again on the next edge.
// ---------------------------------------------------------------------------
module output_layer_mac #(
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  // Must be >= 2*DATA_W+2 so that four full-scale products plus the
  // scaled bias never wrap before the final saturation.
  parameter int ACC_W     = 20,
  parameter int RELU      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] h0,
  input  logic [DATA_W-1:0] h1,
  input  logic [DATA_W-1:0] h2,
  input  logic [DATA_W-1:0] h3,
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w2,
  input  logic [DATA_W-1:0] w3,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int PROD_W = 2 * DATA_W;

  // Rounding constant: one half LSB of the output format.
  localparam logic signed [ACC_W-1:0] HALF_LSB =
    ACC_W'(1) << (FRAC_BITS - 1);

  // Output range limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                   state;
  logic [1:0]               idx;
  logic signed [ACC_W-1:0]  acc;

  // Operands are registered at capture so that upstream may change its
  // ports freely while the MAC runs.
  logic [DATA_W-1:0]        h_r [0:3];
  logic [DATA_W-1:0]        w_r [0:3];

  // Datapath (combinational)
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  bias_scaled;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  r_shift;
  logic signed [ACC_W-1:0]  r_act;
  logic [DATA_W-1:0]        sample_next;

  assign dbg_state = state;

  always_comb begin
    prod        = '0;
    prod_ext    = '0;
    bias_ext    = '0;
    bias_scaled = '0;
    acc_rnd     = '0;
    r_shift     = '0;
    r_act       = '0;
    sample_next = '0;

    // Full-precision signed product of the currently selected pair.
    prod     = $signed(h_r[idx]) * $signed(w_r[idx]);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Bias is in the output format (FRAC_BITS fractional bits) while the
    // products carry 2*FRAC_BITS, so it is aligned by shifting it up.
    bias_ext    = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
    bias_scaled = bias_ext <<< FRAC_BITS;

    // Round half up: add half an LSB, then arithmetic shift (floor).
    acc_rnd = acc + HALF_LSB;
    r_shift = acc_rnd >>> FRAC_BITS;

    // Optional rectification precedes saturation.
    if ((RELU != 0) && (r_shift < 0)) begin
      r_act = '0;
    end else begin
      r_act = r_shift;
    end

    // Narrowing to the output width is the only place values are clipped.
    if (r_act > SAT_MAX) begin
      sample_next = SAT_MAX[DATA_W-1:0];
    end else if (r_act < SAT_MIN) begin
      sample_next = SAT_MIN[DATA_W-1:0];
    end else begin
      sample_next = r_act[DATA_W-1:0];
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sample <= '0;
      acc        <= '0;
      idx        <= '0;
      for (int i = 0; i < 4; i++) begin
        h_r[i] <= '0;
        w_r[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the
          // transfer condition here.
          if (in_valid) begin
            h_r[0]   <= h0;
            h_r[1]   <= h1;
            h_r[2]   <= h2;
            h_r[3]   <= h3;
            w_r[0]   <= w0;
            w_r[1]   <= w1;
            w_r[2]   <= w2;
            w_r[3]   <= w3;
            acc      <= bias_scaled;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end

        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          out_sample <= sample_next;
          out_valid  <= 1'b1;
          state      <= S_HOLD;
        end

        S_HOLD: begin
          // The sample stays put for as long as the consumer stalls.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_mac.sv
// ---------------------------------------------------------------------------
// tb_output_layer_mac
//
// Directed bench for output_layer_mac. Two instances share all inputs: one
// linear (RELU=0) and one rectifying (RELU=1). Every vector carries its
// hand-computed expected sample for both variants; a negedge monitor pops
// the expected queues on each output transfer.
// Inputs are driven 1 time unit after the rising edge; DUT outputs are read
// at that same point (after the edge has settled) or on the falling edge.
// ---------------------------------------------------------------------------
module tb_output_layer_mac;

  localparam int DATA_W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic              in_valid;
  logic              out_ready;
  logic [DATA_W-1:0] h0, h1, h2, h3;
  logic [DATA_W-1:0] w0, w1, w2, w3;
  logic [DATA_W-1:0] bias;

  logic              in_ready,  in_ready_r;
  logic              out_valid, out_valid_r;
  logic [DATA_W-1:0] out_sample, out_sample_r;
  logic [1:0]        dbg_state, dbg_state_r;

  output_layer_mac #(.DATA_W(DATA_W), .FRAC_BITS(4), .ACC_W(20), .RELU(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .dbg_state(dbg_state)
  );

  output_layer_mac #(.DATA_W(DATA_W), .FRAC_BITS(4), .ACC_W(20), .RELU(1)) u_dut_relu (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_r),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_sample(out_sample_r),
    .dbg_state(dbg_state_r)
  );

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_relu_q[$];
  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitors: a transfer occurs at the next rising edge when valid&ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("lin_unexpected_sample", int'($signed(out_sample)), 9999);
      end else begin
        check("lin_sample", int'($signed(out_sample)), int'($signed(exp_q.pop_front())));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_r === 1'b1 && out_ready === 1'b1) begin
      if (exp_relu_q.size() == 0) begin
        check("relu_unexpected_sample", int'($signed(out_sample_r)), 9999);
      end else begin
        check("relu_sample", int'($signed(out_sample_r)), int'($signed(exp_relu_q.pop_front())));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int bb);
    h0 = a0[7:0]; h1 = a1[7:0]; h2 = a2[7:0]; h3 = a3[7:0];
    w0 = b0[7:0]; w1 = b1[7:0]; w2 = b2[7:0]; w3 = b3[7:0];
    bias = bb[7:0];
  endtask

  // Present one operand set, wait for the capture edge, then scramble the
  // ports so any late sampling of the inputs corrupts the result.
  task automatic send(input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3,
                      input int bb, input int e_lin, input int e_relu);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_ready_timeout", 0, 1);
    set_ops(a0, a1, a2, a3, b0, b1, b2, b3, bb);
    in_valid = 1'b1;
    exp_q.push_back(e_lin[7:0]);
    exp_relu_q.push_back(e_relu[7:0]);
    tick();
    in_valid = 1'b0;
    set_ops(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && exp_relu_q.size() == 0 && in_ready === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("done_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",   int'(in_ready),   1);
    check("rst_out_valid",  int'(out_valid),  0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_state",      int'(dbg_state),  0);
    check("rst_relu_ready", int'(in_ready_r), 1);

    out_ready = 1'b1;

    // 16*16*4 = 1024 in Q.8 -> 64 in Q.4; latency 5 edges from capture
    send(16, 16, 16, 16, 16, 16, 16, 16, 0, 64, 64);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    check("latency", k, 5);
    check("t1_sample", int'($signed(out_sample)), 64);
    check("t1_in_ready_busy", int'(in_ready), 0);
    wait_done();

    // Positive saturation: 4*16129 + 127*16 -> 4159 -> 127
    send(127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127);
    wait_done();
    // Negative saturation: 4*(-16256) - 2048 -> -4192 -> -128 (relu: 0)
    send(-128, -128, -128, -128, 127, 127, 127, 127, -128, -128, 0);
    wait_done();
    // acc=8: (8+8)>>>4 = 1, half rounds up
    send(8, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    wait_done();
    // acc=24: 1.5 -> 2
    send(24, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2);
    wait_done();
    // acc=-8: -0.5 -> 0
    send(-8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    wait_done();
    // Bias only: -80 -> (-72)>>>4 = -5 (relu: 0)
    send(0, 0, 0, 0, 5, 5, 5, 5, -5, -5, 0);
    wait_done();
    // Mixed signs: 256-512-768+256 + 32 = -736 -> -46 (relu: 0)
    send(16, -32, 48, -16, 16, 16, -16, -16, 2, -46, 0);
    wait_done();

    // Stalled consumer: 160 + 48 = 208 -> 13
    out_ready = 1'b0;
    send(1, 2, 3, 4, 16, 16, 16, 16, 3, 13, 13);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) check("stall_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_sample", int'($signed(out_sample)), 13);
      check("stall_in_ready", int'(in_ready), 0);
      set_ops(16, 16, 16, 16, 16, 16, 16, 16, 0);
      in_valid = i[0];
      tick();
    end
    // Release: transfer at the next edge, capture on the one after.
    in_valid = 1'b1;
    exp_q.push_back(8'd64);
    exp_relu_q.push_back(8'd64);
    out_ready = 1'b1;
    tick();
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    tick();
    check("recapture_in_ready", int'(in_ready), 0);
    check("recapture_state", int'(dbg_state), 1);
    in_valid = 1'b0;
    wait_done();

    // Reset in the middle of MAC: the in-flight result is discarded.
    send(16, 16, 16, 16, 16, 16, 16, 16, 16, 80, 80);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_sample", int'(out_sample), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_state", int'(dbg_state), 0);
    exp_q.delete();
    exp_relu_q.delete();
    held = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || out_valid_r !== 1'b0) held++;
    end
    check("mid_rst_no_emit", held, 0);

    // Fresh transaction after reset: 1024 + 256 = 1280 -> 80
    send(16, 16, 16, 16, 16, 16, 16, 16, 16, 80, 80);
    wait_done();

    tick();
    tick();
    check("leftover_lin", exp_q.size(), 0);
    check("leftover_relu", exp_relu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
